// File: rtl/spi_regfile_pkg.sv
// Shared types and constants for the SPI register-file front end.
// Build option: SPI_REGFILE_ERR_EN selects the 8'hFF read fill used by the error-checking variant.
package spi_regfile_pkg;

  localparam int ADDR_W     = 4;
  localparam int CMD_WR_BIT = 7;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WRITE,
    RD_LOAD,
    RD_WAIT,
    DRAIN
  } state_t;

`ifdef SPI_REGFILE_ERR_EN
  localparam logic [7:0] READ_FILL = 8'hFF;
`else
  localparam logic [7:0] READ_FILL = 8'h00;
`endif

endpackage

// File: rtl/spi_regfile_bank.sv
// Register bank: one write port, combinational read port, flat view of all registers.
// Build option: SPI_REGFILE_ERR_EN (via READ_FILL) sets the value returned for unmapped addresses.
module spi_regfile_bank
  import spi_regfile_pkg::*;
#(
  parameter int          NUM_REGS = 4,
  parameter logic [7:0]  RST_VAL  = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [7:0]            wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [7:0]            rdata,
  output logic [NUM_REGS*8-1:0] reg_q
);

  logic [7:0] regs [NUM_REGS];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        regs[g] <= RST_VAL;
      else if (we && waddr == ADDR_W'(g))
        regs[g] <= wdata;
    end
    assign reg_q[8*g +: 8] = regs[g];
  end

  // Addresses with no backing register read as the fill value.
  always_comb begin
    rdata = READ_FILL;
    for (int i = 0; i < NUM_REGS; i++)
      if (raddr == ADDR_W'(i)) rdata = regs[i];
  end

endmodule

// File: rtl/spi_slave_regfile.sv
// Decodes SPI frames (command byte, then data/dummy bytes) into register reads and writes.
// Build option: SPI_REGFILE_ERR_EN enables the sticky err flag and the DRAIN state.
module spi_slave_regfile
  import spi_regfile_pkg::*;
#(
  parameter int          NUM_REGS = 4,
  parameter logic [7:0]  RST_VAL  = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic [7:0]            si_data,
  input  logic                  si_done,
  output logic [7:0]            so_data,
  output logic                  so_start,
  input  logic                  so_ready,
  output logic [NUM_REGS*8-1:0] reg_q,
  output logic                  wr_stb,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic                  err
);

  localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        so_data_q, so_data_d;
  logic [7:0]        rdata;
  logic              we;
  logic              addr_in_range;

  assign addr_in_range = {1'b0, addr_q} < NREGS;

`ifdef SPI_REGFILE_ERR_EN
  logic err_set;
  logic err_q;
  logic cmd_in_range;
  logic last_reg;

  assign cmd_in_range = {1'b0, si_data[ADDR_W-1:0]} < NREGS;
  // With 16 registers the pointer wraps inside the map, so there is no edge to cross.
  assign last_reg     = (NUM_REGS < 16) && ({1'b0, addr_q} == NREGS - 1'b1);
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    so_data_d = so_data_q;
    so_start  = 1'b0;
    we        = 1'b0;
`ifdef SPI_REGFILE_ERR_EN
    err_set   = 1'b0;
`endif
    // Frame end wins over everything, including a byte landing in the same cycle.
    if (cs && state_q != IDLE) begin
      state_d = IDLE;
      addr_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (!cs) state_d = CMD;
        CMD: if (si_done) begin
          addr_d  = si_data[ADDR_W-1:0];
          state_d = si_data[CMD_WR_BIT] ? WRITE : RD_LOAD;
`ifdef SPI_REGFILE_ERR_EN
          if (!cmd_in_range) begin
            err_set = 1'b1;
            state_d = DRAIN;
            if (!si_data[CMD_WR_BIT]) so_data_d = READ_FILL;
          end
`endif
        end
        WRITE: if (si_done) begin
          we     = addr_in_range;
          addr_d = addr_q + 1'b1;
`ifdef SPI_REGFILE_ERR_EN
          if (last_reg) begin
            err_set = 1'b1;
            state_d = DRAIN;
          end
`endif
        end
        RD_LOAD: if (so_ready) begin
          so_start  = 1'b1;
          so_data_d = rdata;
          state_d   = RD_WAIT;
        end
        RD_WAIT: if (si_done) begin
          addr_d  = addr_q + 1'b1;
          state_d = RD_LOAD;
`ifdef SPI_REGFILE_ERR_EN
          if (last_reg) begin
            err_set   = 1'b1;
            state_d   = DRAIN;
            so_data_d = READ_FILL;
          end
`endif
        end
        DRAIN: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // The load byte is presented combinationally so it lines up with so_start.
  assign so_data = so_start ? rdata : so_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      so_data_q <= 8'h00;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      so_data_q <= so_data_d;
      wr_stb    <= we;
      if (we) wr_addr <= addr_q;
    end
  end

`ifdef SPI_REGFILE_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  spi_regfile_bank #(
    .NUM_REGS(NUM_REGS),
    .RST_VAL (RST_VAL)
  ) u_bank (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .waddr(addr_q),
    .wdata(si_data),
    .raddr(addr_q),
    .rdata(rdata),
    .reg_q(reg_q)
  );

endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- Register-file front end sitting directly downstream of spi_slave.
- Consumes received bytes (si_data/si_done) and decodes per-frame command/address/data.
- Writes an internal register bank; for reads, feeds response bytes back through the slave's transmit handshake (so_data/so_start/so_ready).
- Registers are exposed flat to fabric logic, with a write strobe.

Parameters:
- NUM_REGS, 4, number of 8-bit registers (1..16); command address field is fixed 4 bits.
- RST_VAL, 8'h00, reset value of every register.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- cs  input  1  SPI chip select (active low), frame delimiter.
- si_data  input  8  byte received by spi_slave.
- si_done  input  1  one-cycle pulse: si_data valid.
- so_data  output  8  byte to load into spi_slave transmit shifter.
- so_start  output  1  one-cycle load pulse to spi_slave.
- so_ready  input  1  spi_slave can accept so_data.
- reg_q  output  NUM_REGS*8  flattened register contents, reg n at [8n+7:8n].
- wr_stb  output  1  one-cycle pulse per committed register write.
- wr_addr  output  4  address of committed write, valid with wr_stb.
- err  output  1  sticky error; only present with SPI_REGFILE_ERR_EN, otherwise tied 0.

Behaviour:
- Reset (async): state IDLE, all registers RST_VAL, so_data 8'h00, so_start 0, wr_stb 0, wr_addr 0, err 0, addr pointer 0.
- Frame: cs low..cs high. First si_done byte of a frame is the command: bit7=1 write, 0 read; bits[6:4] ignored; bits[3:0] start address.
- FSM states:
  - IDLE: wait cs=0 -> CMD.
  - CMD: on si_done, latch addr=si_data[3:0]. Write command -> WRITE; read command -> RD_LOAD.
  - WRITE: each si_done writes si_data to reg[addr] on the next clock edge, pulses wr_stb for 1 cycle with wr_addr=addr, then addr<=addr+1.
  - RD_LOAD: wait so_ready=1. Drive so_data=reg[addr] and so_start=1 for exactly one cycle -> RD_WAIT.
  - RD_WAIT: on si_done (master's dummy byte clocked out), addr<=addr+1 -> RD_LOAD.
- cs=1 in any non-IDLE state -> IDLE next cycle; pointer cleared. cs rising takes priority over a coincident si_done: that byte is discarded, with no write and no strobe.
- Address increment is 4-bit modulo 16: 4'hF+1=4'h0.
- Out-of-range address (addr>=NUM_REGS): writes dropped (no wr_stb); reads return 8'h00; pointer still increments.
- Write latency: register visible on reg_q one clock after the si_done cycle.
- Read latency: so_start no earlier than one cycle after the command si_done, gated by so_ready. so_start is never asserted while so_ready=0.
- so_data holds its last value between loads.
- Reset mid-frame: everything returns to reset values immediately; the frame is abandoned.

Optional Feature:
- Macro SPI_REGFILE_ERR_EN.
- Defined: err is set (sticky until reset) when a command addresses >=NUM_REGS, or when auto-increment crosses NUM_REGS-1. The offending frame is ignored from that byte onward; FSM parks in a DRAIN state until cs=1. Reads then return 8'hFF, not 8'h00.
- Undefined: err tied 0, no DRAIN state; behaviour as above.

Decomposition:
- Package spi_regfile_pkg: state enum typedef (IDLE, CMD, WRITE, RD_LOAD, RD_WAIT, DRAIN), CMD_WR_BIT=7, ADDR_W=4, localparam READ_FILL values (8'h00 / 8'hFF).
- Sub-module spi_regfile_bank: register array with write port (we, waddr, wdata), combinational read port, and flattened reg_q.

Test Plan:
- Write 0x81,0x5A,0xC3 in one frame -> reg1=0x5A, reg2=0xC3; two wr_stb pulses at addr 1,2; reg0/reg3=0x00.
- Read: after above, frame 0x01,dummy,dummy -> so_data 0x5A then 0xC3, each so_start exactly one cycle, only while so_ready=1.
- Wrap (NUM_REGS=16): write frame 0x8F,0x11,0x22 -> reg15=0x11, reg0=0x22.
- Abort: cs rises coincident with si_done of the second data byte in frame 0x80,0xAA,0xBB -> reg0=0xAA, reg1 unchanged; FSM back in IDLE; next frame decodes normally.
- Out-of-range (NUM_REGS=4): write 0x86,0x77 -> no wr_stb, no change; read 0x06 -> so_data 0x00. With SPI_REGFILE_ERR_EN: err=1, read returns 0xFF, err persists until reset.
- Async reset asserted mid-read frame -> all outputs at reset values within the same cycle; reg_q all RST_VAL.
